// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: one-hot column drive, synchronised row sampling, scan-level
// press/release debounce, and a seven-segment readout of the last accepted key.
module keypad_scan_ctrl #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  localparam int unsigned IdxW          = $clog2(ROWS * COLS)
) (
  input  logic            CLOCK_50,
  input  logic            RESET_N,
  output logic [COLS-1:0] COL,
  input  logic [ROWS-1:0] ROW,
  output logic [IdxW-1:0] key_index,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic            key_held,
  output logic [6:0]      HEX0
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned ColW = $clog2(COLS);
  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {StIdle, StCand, StPressed, StRel} state_e;

  function automatic logic [3:0] keymap(input logic [IdxW-1:0] idx);
    logic [3:0] idx4;
    idx4 = 4'(idx);
    if (ROWS != 4 || COLS != 4) return idx4;
    case (idx4)
      4'd0:  return 4'h1;
      4'd1:  return 4'h2;
      4'd2:  return 4'h3;
      4'd3:  return 4'hA;
      4'd4:  return 4'h4;
      4'd5:  return 4'h5;
      4'd6:  return 4'h6;
      4'd7:  return 4'hB;
      4'd8:  return 4'h7;
      4'd9:  return 4'h8;
      4'd10: return 4'h9;
      4'd11: return 4'hC;
      4'd12: return 4'hE;
      4'd13: return 4'h0;
      4'd14: return 4'hF;
      4'd15: return 4'hD;
      default: return idx4;
    endcase
  endfunction

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7seg(input logic [3:0] code);
    case (code)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      4'hF: return 7'b0001110;
      default: return 7'h7F;
    endcase
  endfunction

  logic [ROWS-1:0] row_s1, row_s2;
  logic [DivW-1:0] div_cnt;
  logic [ColW-1:0] col_idx;
  logic [1:0]      hit_cnt;
  logic [IdxW-1:0] hit_idx;
  state_e          state;
  logic [IdxW-1:0] cand_idx;
  logic [CntW-1:0] deb_cnt;

  logic            slot_end, scan_end, scan_none, scan_single;
  logic [1:0]      col_hits, sum_cnt;
  logic [2:0]      sum_raw;
  logic [RowW-1:0] col_row;
  logic [IdxW-1:0] sum_idx;
  logic [3:0]      acc_code;
  logic [6:0]      acc_hex;
  logic [CntW-1:0] deb_next;

  assign slot_end    = (div_cnt == DivW'(SCAN_DIV - 1));
  assign scan_end    = slot_end && (col_idx == ColW'(COLS - 1));
  assign scan_none   = (sum_cnt == 2'd0);
  assign scan_single = (sum_cnt == 2'd1);

  // Hit count saturates at 2: anything beyond one closed switch is ghosting.
  always_comb begin
    col_hits = 2'd0;
    col_row  = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (row_s2[r]) begin
        col_hits = (col_hits == 2'd0) ? 2'd1 : 2'd2;
        col_row  = RowW'(r);
      end
    end
    sum_raw  = {1'b0, hit_cnt} + {1'b0, col_hits};
    sum_cnt  = (sum_raw >= 3'd2) ? 2'd2 : sum_raw[1:0];
    sum_idx  = (col_hits != 2'd0) ? IdxW'(col_row * COLS + col_idx) : hit_idx;
    acc_code = keymap(sum_idx);
    acc_hex  = hex7seg(acc_code);
    deb_next = deb_cnt + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      row_s1    <= '0;
      row_s2    <= '0;
      div_cnt   <= '0;
      col_idx   <= '0;
      COL       <= COLS'(1);
      hit_cnt   <= '0;
      hit_idx   <= '0;
      state     <= StIdle;
      cand_idx  <= '0;
      deb_cnt   <= '0;
      key_index <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      HEX0      <= 7'h7F;
    end else begin
      row_s1    <= ROW;
      row_s2    <= row_s1;
      key_valid <= 1'b0;

      if (!slot_end) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        COL     <= {COL[COLS-2:0], COL[COLS-1]};
        col_idx <= (col_idx == ColW'(COLS - 1)) ? '0 : col_idx + 1'b1;
        hit_cnt <= scan_end ? '0 : sum_cnt;
        hit_idx <= scan_end ? '0 : sum_idx;
      end

      if (scan_end) begin
        case (state)
          StIdle: begin
            if (scan_single) begin
              if (DEBOUNCE_SCANS == 1) begin
                state     <= StPressed;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                key_index <= sum_idx;
                key_code  <= acc_code;
                HEX0      <= acc_hex;
              end else begin
                state    <= StCand;
                cand_idx <= sum_idx;
                deb_cnt  <= CntW'(1);
              end
            end
          end
          StCand: begin
            if (scan_single && sum_idx == cand_idx) begin
              if (deb_next == CntW'(DEBOUNCE_SCANS)) begin
                state     <= StPressed;
                deb_cnt   <= '0;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                key_index <= sum_idx;
                key_code  <= acc_code;
                HEX0      <= acc_hex;
              end else begin
                deb_cnt <= deb_next;
              end
            end else if (scan_single) begin
              cand_idx <= sum_idx;
              deb_cnt  <= CntW'(1);
            end else begin
              state   <= StIdle;
              deb_cnt <= '0;
            end
          end
          StPressed: begin
            if (scan_none) begin
              if (DEBOUNCE_SCANS == 1) begin
                state    <= StIdle;
                key_held <= 1'b0;
              end else begin
                state   <= StRel;
                deb_cnt <= CntW'(1);
              end
            end
          end
          StRel: begin
            if (scan_none) begin
              if (deb_next == CntW'(DEBOUNCE_SCANS)) begin
                state    <= StIdle;
                deb_cnt  <= '0;
                key_held <= 1'b0;
              end else begin
                deb_cnt <= deb_next;
              end
            end else begin
              state   <= StPressed;
              deb_cnt <= '0;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a scan-level keypad/debounce model checked every cycle,
// directed scenarios with literal expectations, then randomized key activity.
module tb_keypad_scan_ctrl;

  localparam int R    = 4;
  localparam int C    = 4;
  localparam int D    = 4;
  localparam int DB   = 3;
  localparam int SCAN = C * D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_index, key_code;
  logic        key_valid, key_held;
  logic [6:0]  hex0;
  logic [15:0] keys;

  keypad_scan_ctrl #(
    .ROWS(R), .COLS(C), .SCAN_DIV(D), .DEBOUNCE_SCANS(DB)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .COL      (col),
    .ROW      (row),
    .key_index(key_index),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .HEX0     (hex0)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed switch connects its column drive to its row.
  always_comb begin
    row = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (keys[r*C+c] && col[c]) row[r] = 1'b1;
  end

  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_fail   = 0;
  int dut_pulses = 0;
  int exp_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model (scan level) ----------------
  int unsigned cyc;
  logic [15:0] seen;
  int          phase;   // 0 idle, 1 candidate, 2 pressed, 3 releasing
  int          m_cnt, m_cand;
  logic        exp_valid, exp_held;
  logic [3:0]  exp_idx, exp_code;
  logic [6:0]  exp_hex;

  task automatic model_reset();
    cyc = 0; seen = '0; phase = 0; m_cnt = 0; m_cand = 0;
    exp_valid = 1'b0; exp_held = 1'b0; exp_idx = '0; exp_code = '0; exp_hex = 7'h7F;
  endtask

  task automatic model_accept(input int idx);
    exp_valid = 1'b1;
    exp_held  = 1'b1;
    exp_idx   = 4'(idx);
    exp_code  = kmap[idx];
    exp_hex   = font[kmap[idx]];
    exp_pulses++;
  endtask

  task automatic scan_eval();
    int n, idx;
    n = $countones(seen);
    idx = 0;
    for (int i = 0; i < 16; i++) if (seen[i]) idx = i;
    case (phase)
      0: if (n == 1) begin
           m_cand = idx; m_cnt = 1; phase = 1;
           if (m_cnt >= DB) begin model_accept(idx); phase = 2; end
         end
      1: if (n == 1 && idx == m_cand) begin
           m_cnt++;
           if (m_cnt >= DB) begin model_accept(idx); phase = 2; end
         end else if (n == 1) begin
           m_cand = idx; m_cnt = 1;
         end else phase = 0;
      2: if (n == 0) begin m_cnt = 1; phase = 3; end
      default: if (n == 0) begin
           m_cnt++;
           if (m_cnt >= DB) begin phase = 0; exp_held = 1'b0; end
         end else begin phase = 2; m_cnt = 0; end
    endcase
  endtask

  // Rows reach the sampler two cycles late, so the DUT sees the keys of cycle D-3 in a slot.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        exp_valid = 1'b0;
        if (cyc % D == D - 3) begin
          int c;
          c = (cyc / D) % C;
          for (int r = 0; r < R; r++) seen[r*C+c] = keys[r*C+c];
        end
        if (cyc % SCAN == SCAN - 1) begin
          scan_eval();
          seen = '0;
        end
        cyc++;
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      logic [3:0] exp_col;
      @(negedge clk);
      exp_col = 4'(1 << ((cyc / D) % C));
      chk("col",       32'(col),       32'(exp_col));
      chk("key_valid", 32'(key_valid), 32'(exp_valid));
      chk("key_held",  32'(key_held),  32'(exp_held));
      chk("key_index", 32'(key_index), 32'(exp_idx));
      chk("key_code",  32'(key_code),  32'(exp_code));
      chk("hex0",      32'(hex0),      32'(exp_hex));
      if (key_valid === 1'b1) dut_pulses++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  task automatic to_scan_start();
    do begin @(posedge clk); #1; end while (cyc % SCAN != 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_col"},   32'(col),       32'h1);
    chk({tag, "_valid"}, 32'(key_valid), 32'h0);
    chk({tag, "_held"},  32'(key_held),  32'h0);
    chk({tag, "_idx"},   32'(key_index), 32'h0);
    chk({tag, "_code"},  32'(key_code),  32'h0);
    chk({tag, "_hex"},   32'(hex0),      32'h7F);
  endtask

  initial begin
    int pb;
    rst_n = 1'b0;
    keys  = '0;
    repeat (3) @(negedge clk);
    #2;
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Column rotation every D cycles.
    wait_cyc(4);  chk("col_step1", 32'(col), 32'h2);
    wait_cyc(8);  chk("col_step2", 32'(col), 32'h4);
    wait_cyc(12); chk("col_step3", 32'(col), 32'h8);
    wait_cyc(16); chk("col_wrap",  32'(col), 32'h1);

    // Key '6' (row1/col2) closed at the start of scan 1; accepted after scan 3 ends.
    keys = 16'h0040;
    wait_cyc(63); chk("press6_early", 32'(key_valid), 32'h0);
    wait_cyc(64);
    chk("press6_valid", 32'(key_valid), 32'h1);
    chk("press6_idx",   32'(key_index), 32'd6);
    chk("press6_code",  32'(key_code),  32'h6);
    chk("press6_hex",   32'(hex0),      32'b0000010);
    chk("press6_held",  32'(key_held),  32'h1);
    wait_cyc(65); chk("press6_onecycle", 32'(key_valid), 32'h0);

    // Short release is absorbed; a full release drops key_held.
    wait_cyc(80);  keys = '0;
    wait_cyc(96);  keys = 16'h0040;
    wait_cyc(120);
    chk("glitch_held",   32'(key_held), 32'h1);
    chk("glitch_pulses", 32'(dut_pulses), 32'd1);
    wait_cyc(128); keys = '0;
    wait_cyc(175); chk("release_late", 32'(key_held), 32'h1);
    wait_cyc(176); chk("release_done", 32'(key_held), 32'h0);
    keys = 16'h2000;  // row3/col1 -> '0'
    wait_cyc(224);
    chk("press0_valid", 32'(key_valid), 32'h1);
    chk("press0_idx",   32'(key_index), 32'd13);
    chk("press0_code",  32'(key_code),  32'h0);
    chk("press0_hex",   32'(hex0),      32'b1000000);
    wait_cyc(240); keys = '0;
    chk("press0_pulses", 32'(dut_pulses), 32'd2);
    wait_cyc(304);

    // Bouncing contact: no pulse while bouncing, one pulse once it settles.
    to_scan_start();
    pb = dut_pulses;
    for (int i = 0; i < 12; i++) begin keys = keys ^ 16'h0040; cycles(5); end
    chk("bounce_quiet", 32'(dut_pulses - pb), 32'd0);
    keys = 16'h0040;
    cycles(80);
    chk("bounce_one", 32'(dut_pulses - pb), 32'd1);
    keys = '0;
    cycles(4 * SCAN);

    // Two keys together look like ghosting and are never accepted.
    to_scan_start();
    pb = dut_pulses;
    keys = 16'h0801;
    cycles(10 * SCAN);
    chk("multi_pulses", 32'(dut_pulses - pb), 32'd0);
    chk("multi_held",   32'(key_held),       32'h0);
    chk("multi_hex",    32'(hex0),           32'b0000010);
    keys = '0;
    cycles(4 * SCAN);

    // Reset in the middle of debouncing row0/col3 aborts the press.
    to_scan_start();
    pb = dut_pulses;
    keys = 16'h0008;
    cycles(2 * SCAN + 5);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("abort");
    keys = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    chk("abort_col", 32'(col), 32'h1);
    cycles(5 * SCAN);
    chk("abort_pulses", 32'(dut_pulses - pb), 32'd0);

    // Randomized key activity against the model.
    for (int it = 0; it < 40; it++) begin
      int kind, dur, a, b;
      kind = int'($urandom_range(0, 3));
      dur  = int'($urandom_range(8, 120));
      a    = int'($urandom_range(0, 15));
      b    = int'($urandom_range(0, 15));
      case (kind)
        0:       keys = '0;
        1:       keys = 16'(1 << a);
        2:       keys = 16'(1 << a) | 16'(1 << b);
        default: keys = 16'(1 << a);
      endcase
      for (int i = 0; i < dur; i++) begin
        if (kind == 3 && $urandom_range(0, 3) == 0) keys = keys ^ 16'(1 << a);
        cycles(1);
      end
    end
    keys = '0;
    cycles(4 * SCAN);
    chk("pulse_total", 32'(dut_pulses), 32'(exp_pulses));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
